// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory port controller.
// Owner encoding is chosen so that RR_INIT=0 selects requester B as last-served.
package dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRmwRd,
        StWr,
        StDone
    } state_e;

    localparam logic       OWNER_A = 1'b1;
    localparam logic       OWNER_B = 1'b0;
    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way combinational arbiter: round-robin on ties, or fixed priority to A when mode=1.
module dmem_rr_arb2
    import dmem_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic mode,
    output logic grant_b
);

    always_comb begin
        grant_b = 1'b0;
        if (req_b) begin
            if (!req_a) begin
                grant_b = 1'b1;
            end else if (!mode && (last == OWNER_A)) begin
                grant_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Shares a single-port word memory between requesters A and B; partial-byte stores
// are turned into a read-modify-write sequence on the word-only memory.
module dmem_port_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned RR_INIT  = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_be,
    output logic        a_done,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_be,
    output logic        b_done,
    output logic [31:0] b_rdata,

    output logic        busy,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_i,
    input  logic [31:0] mem_data_o
);

    localparam logic ArbMode = (ARB_MODE != 0);
    localparam logic RrReset = (RR_INIT != 0) ? OWNER_A : OWNER_B;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rr_last_q, rr_last_d;

    logic        grant_b;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] merged;

    dmem_rr_arb2 u_arb (
        .req_a   (a_req),
        .req_b   (b_req),
        .last    (rr_last_q),
        .mode    (ArbMode),
        .grant_b (grant_b)
    );

    assign sel_we = grant_b ? b_we : a_we;
    assign sel_be = grant_b ? b_be : a_be;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : merge_q[8*i +: 8];
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        rr_last_d = rr_last_q;

        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    owner_d = grant_b ? OWNER_B : OWNER_A;
                    we_d    = sel_we;
                    addr_d  = grant_b ? b_addr : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                    be_d    = sel_be;
                    if (!sel_we) begin
                        state_d = StRd;
                    end else if (sel_be == BE_FULL) begin
                        state_d = StWr;
                    end else if (sel_be == 4'h0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd: begin
                rdata_d = mem_data_o;
                state_d = StDone;
            end
            StRmwRd: begin
                merge_d = mem_data_o;
                state_d = StWr;
            end
            StWr: begin
                state_d = StDone;
            end
            StDone: begin
                rr_last_d = owner_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= OWNER_B;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            merge_q   <= '0;
            rdata_q   <= '0;
            rr_last_q <= RrReset;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            merge_q   <= merge_d;
            rdata_q   <= rdata_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Memory strobes depend on state only so a requester cannot glitch the memory.
    always_comb begin
        busy       = (state_q != StIdle);
        mem_ren    = (state_q == StRd) || (state_q == StRmwRd);
        mem_wen    = (state_q == StWr);
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_data_i = (state_q == StWr) ? merged : 32'h0;
        a_done     = (state_q == StDone) && (owner_q == OWNER_A);
        b_done     = (state_q == StDone) && (owner_q == OWNER_B);
        a_rdata    = (a_done && !we_q) ? rdata_q : 32'h0;
        b_rdata    = (b_done && !we_q) ? rdata_q : 32'h0;
    end

endmodule
